// File: rtl/aftab_demux1to2_reg_if.sv
// Handshake bundle for the AFTAB registered 1-to-2 demultiplexer.
// Carries the producer side (i/valid_in/ready_in/s0/s1) and both output
// ports (w_k/valid_k/ready_k). The drop counter signal only exists when
// AFTAB_DEMUX_DROP_CNT_EN is defined.
interface aftab_demux1to2_reg_if #(
  parameter int size = 32
);
  logic [size-1:0] i;
  logic            valid_in;
  logic            ready_in;
  logic            s0;
  logic            s1;
  logic [size-1:0] w0;
  logic            valid0;
  logic            ready0;
  logic [size-1:0] w1;
  logic            valid1;
  logic            ready1;
`ifdef AFTAB_DEMUX_DROP_CNT_EN
  logic [7:0]      drop_cnt;

  // Demultiplexer view: consumes the input word, drives both output ports
  modport slave (
    input  i, valid_in, s0, s1, ready0, ready1,
    output ready_in, w0, valid0, w1, valid1, drop_cnt
  );

  // Environment view: producer of the input word and consumer of both ports
  modport master (
    output i, valid_in, s0, s1, ready0, ready1,
    input  ready_in, w0, valid0, w1, valid1, drop_cnt
  );
`else
  // Demultiplexer view: consumes the input word, drives both output ports
  modport slave (
    input  i, valid_in, s0, s1, ready0, ready1,
    output ready_in, w0, valid0, w1, valid1
  );

  // Environment view: producer of the input word and consumer of both ports
  modport master (
    output i, valid_in, s0, s1, ready0, ready1,
    input  ready_in, w0, valid0, w1, valid1
  );
`endif
endinterface

// File: rtl/aftab_demux1to2_reg.sv
// aftab_demux1to2_reg: registered 1-to-2 demultiplexer for the AFTAB datapath.
// One input word with valid/ready is steered by priority selects (s0 over s1)
// into one of two single-entry holding registers, each with its own
// valid/ready handshake. Words with neither select set are consumed and
// discarded. Reset is synchronous and active-low.
// Optional feature: define AFTAB_DEMUX_DROP_CNT_EN to add a saturating
// 8-bit counter of discarded words (drop_cnt).
module aftab_demux1to2_reg (
  input logic                    clk,
  input logic                    rst,
  aftab_demux1to2_reg_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_t;

  port_state_t state0;
  port_state_t state1;

  logic sel0;
  logic sel1;
  logic sel_drop;
  logic can_accept0;
  logic can_accept1;
  logic accept;

  // Select decode and per-port space check; ready_in never looks at valid_in
  always_comb begin
    sel0        = bus.s0;
    sel1        = ~bus.s0 & bus.s1;
    sel_drop    = ~bus.s0 & ~bus.s1;
    can_accept0 = (state0 == EMPTY) | bus.ready0;
    can_accept1 = (state1 == EMPTY) | bus.ready1;
    if (sel0) begin
      bus.ready_in = can_accept0;
    end else if (sel1) begin
      bus.ready_in = can_accept1;
    end else begin
      bus.ready_in = 1'b1;
    end
    accept = bus.valid_in & bus.ready_in;
  end

  assign bus.valid0 = (state0 == FULL);
  assign bus.valid1 = (state1 == FULL);

  // Port 0 holding register: refill on accept, otherwise drain when taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      state0 <= EMPTY;
      bus.w0 <= '0;
    end else if (accept && sel0) begin
      state0 <= FULL;
      bus.w0 <= bus.i;
    end else if ((state0 == FULL) && bus.ready0) begin
      state0 <= EMPTY;
    end
  end

  // Port 1 holding register: refill on accept, otherwise drain when taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      state1 <= EMPTY;
      bus.w1 <= '0;
    end else if (accept && sel1) begin
      state1 <= FULL;
      bus.w1 <= bus.i;
    end else if ((state1 == FULL) && bus.ready1) begin
      state1 <= EMPTY;
    end
  end

`ifdef AFTAB_DEMUX_DROP_CNT_EN
  // Count accepted drops, sticking at all-ones until the next reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.drop_cnt <= 8'h00;
    end else if (accept && sel_drop && (bus.drop_cnt != 8'hFF)) begin
      bus.drop_cnt <= bus.drop_cnt + 8'h01;
    end
  end
`else
  // Without the counter a drop is simply consumed; sel_drop has no other use
  logic drop_unused;
  assign drop_unused = sel_drop;
`endif

endmodule

// File: tb/tb_aftab_demux1to2_reg.sv
// Testbench for aftab_demux1to2_reg: a directed vector table, hand-written
// streaming and drop sequences, then randomized traffic checked against a
// queue-based reference model. Checks drop_cnt only when
// AFTAB_DEMUX_DROP_CNT_EN is defined.
module tb_aftab_demux1to2_reg;

  logic clk;
  logic rst;

  int compared;
  int mismatched;

  aftab_demux1to2_reg_if bus ();

  aftab_demux1to2_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        vin;
    logic        s0;
    logic        s1;
    logic [31:0] din;
    logic        rdy0;
    logic        rdy1;
    logic        chk_rdy;
    logic        exp_rdy;
    logic        exp_v0;
    logic [31:0] exp_w0;
    logic        exp_v1;
    logic [31:0] exp_w1;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[12];

  // Reference model: each port is a queue of capacity one plus the last
  // word written (the data output holds after a drain)
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] last0;
  logic [31:0] last1;
  int          mcnt;

  task automatic applyStimulus(input logic rst_v, input logic vin, input logic s0v,
                               input logic s1v, input logic [31:0] din,
                               input logic r0, input logic r1);
    rst          = rst_v;
    bus.valid_in = vin;
    bus.s0       = s0v;
    bus.s1       = s1v;
    bus.i        = din;
    bus.ready0   = r0;
    bus.ready1   = r1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    mcnt  = 0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // rst_n vin s0 s1 din rdy0 rdy1 chk exp_rdy v0 w0 v1 w1 cnt
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b0, 32'h0, 1'b0, 32'h0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 32'hA5A5_0001, 1'b0, 32'h0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 32'hA5A5_0001, 1'b1, 32'h2, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0033, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 32'hA5A5_0001, 1'b1, 32'h2, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b1, 32'h33, 1'b1, 32'h2, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b1,
                 1'b1, 32'h33, 1'b0, 32'h2, 8'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 32'h33, 1'b1, 32'h44, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0055, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 32'h55, 1'b0, 32'h44, 8'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0066, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b0, 32'h55, 1'b0, 32'h44, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b0, 32'h55, 1'b0, 32'h44, 8'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0088, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b0, 32'h0, 1'b0, 32'h0, 8'd0};

    @(posedge clk);
    #1;

    // Directed table: ready_in before the edge, registered outputs after it
    for (int n = 0; n < 12; n++) begin
      applyStimulus(vecs[n].rst_n, vecs[n].vin, vecs[n].s0, vecs[n].s1,
                    vecs[n].din, vecs[n].rdy0, vecs[n].rdy1);
      @(negedge clk);
      if (vecs[n].chk_rdy) checkOutput($sformatf("vec%0d ready_in", n), {31'b0, bus.ready_in},
                                       {31'b0, vecs[n].exp_rdy});
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d valid0", n), {31'b0, bus.valid0}, {31'b0, vecs[n].exp_v0});
      checkOutput($sformatf("vec%0d w0", n), bus.w0, vecs[n].exp_w0);
      checkOutput($sformatf("vec%0d valid1", n), {31'b0, bus.valid1}, {31'b0, vecs[n].exp_v1});
      checkOutput($sformatf("vec%0d w1", n), bus.w1, vecs[n].exp_w1);
`ifdef AFTAB_DEMUX_DROP_CNT_EN
      checkOutput($sformatf("vec%0d drop_cnt", n), {24'b0, bus.drop_cnt},
                  {24'b0, vecs[n].exp_cnt});
`endif
    end

    // Streaming: four back-to-back words into port 1 with ready1 held high
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, k, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("stream%0d ready_in", k), {31'b0, bus.ready_in}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("stream%0d valid1", k), {31'b0, bus.valid1}, 32'd1);
      checkOutput($sformatf("stream%0d w1", k), bus.w1, k);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("stream drain valid1", {31'b0, bus.valid1}, 32'd0);
    checkOutput("stream drain w1", bus.w1, 32'd4);

    // Drop: reset, then 300 discarded words
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, $urandom, $urandom_range(0, 1),
                    $urandom_range(0, 1));
      @(negedge clk);
      checkOutput("drop ready_in", {31'b0, bus.ready_in}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("drop valids", {30'b0, bus.valid1, bus.valid0}, 32'd0);
      checkOutput("drop w0", bus.w0, 32'd0);
      checkOutput("drop w1", bus.w1, 32'd0);
`ifdef AFTAB_DEMUX_DROP_CNT_EN
      checkOutput($sformatf("drop%0d drop_cnt", k), {24'b0, bus.drop_cnt},
                  (k > 255) ? 32'd255 : k);
`endif
    end

    // Randomized traffic against the queue model
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    modelReset();
    begin
      logic        pending;
      logic        r_rst, r_vin, r_s0, r_s1, r_r0, r_r1;
      logic [31:0] r_din;
      int          target;
      logic        room0, room1, exp_rdy, acc;
      pending = 1'b0;
      r_vin = 1'b0; r_s0 = 1'b0; r_s1 = 1'b0; r_din = '0;
      for (int c = 0; c < 3000; c++) begin
        r_rst = ($urandom_range(0, 99) != 0);
        if (!pending) begin
          r_vin = ($urandom_range(0, 3) != 0);
          r_s0  = $urandom_range(0, 1);
          r_s1  = $urandom_range(0, 1);
          r_din = $urandom;
        end
        r_r0 = ($urandom_range(0, 2) != 0);
        r_r1 = ($urandom_range(0, 2) != 0);
        applyStimulus(r_rst, r_vin, r_s0, r_s1, r_din, r_r0, r_r1);

        target  = r_s0 ? 0 : (r_s1 ? 1 : 2);
        room0   = (q0.size() == 0) || r_r0;
        room1   = (q1.size() == 0) || r_r1;
        exp_rdy = (target == 0) ? room0 : ((target == 1) ? room1 : 1'b1);
        acc     = r_vin && exp_rdy;

        @(negedge clk);
        checkOutput("rand ready_in", {31'b0, bus.ready_in}, {31'b0, exp_rdy});
        @(posedge clk);
        #1;

        if (!r_rst) begin
          modelReset();
          pending = 1'b0;
        end else begin
          if (r_r0 && q0.size() > 0) void'(q0.pop_front());
          if (r_r1 && q1.size() > 0) void'(q1.pop_front());
          if (acc && target == 0) begin q0.push_back(r_din); last0 = r_din; end
          if (acc && target == 1) begin q1.push_back(r_din); last1 = r_din; end
          if (acc && target == 2 && mcnt < 255) mcnt++;
          pending = r_vin && !acc;
        end

        checkOutput("rand valid0", {31'b0, bus.valid0}, (q0.size() != 0) ? 32'd1 : 32'd0);
        checkOutput("rand w0", bus.w0, last0);
        checkOutput("rand valid1", {31'b0, bus.valid1}, (q1.size() != 0) ? 32'd1 : 32'd0);
        checkOutput("rand w1", bus.w1, last1);
`ifdef AFTAB_DEMUX_DROP_CNT_EN
        checkOutput("rand drop_cnt", {24'b0, bus.drop_cnt}, mcnt);
`endif
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
